// File: rtl/tape_pkg.sv
// rtl/tape_pkg.sv - shared types and symbol helpers for the tape symbol packer
`timescale 1ns/1ps

package tape_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_PAD   = 2'd2,
        ST_DONE  = 2'd3
    } tape_state_t;

    function automatic int symbols_per_byte(input int symbol_w);
        if (symbol_w <= 0) return 1;
        return 8 / symbol_w;
    endfunction

    // Returns the idx-th symbol of byte b, right-justified in an 8-bit word.
    function automatic logic [7:0] sym_select(input logic [7:0] b,
                                              input logic [2:0] idx,
                                              input int symbol_w,
                                              input int msb_first);
        int         sh;
        logic [7:0] mask;
        mask = 8'hFF >> (8 - symbol_w);
        if (msb_first != 0) sh = 8 - symbol_w * (int'(idx) + 1);
        else                sh = symbol_w * int'(idx);
        return (b >> sh) & mask;
    endfunction

endpackage

// File: rtl/tape_line_counter.sv
// rtl/tape_line_counter.sv - modulo-LINE_SYMBOLS position counter with wrap pulse
`timescale 1ns/1ps

module tape_line_counter #(
    parameter int LINE_SYMBOLS = 320,
    parameter int POS_W        = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [POS_W-1:0] pos,
    output logic             wrap
);

    localparam logic [POS_W-1:0] LAST = POS_W'(LINE_SYMBOLS - 1);

    assign wrap = en && (pos == LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pos <= '0;
        end else if (wrap) begin
            pos <= '0;
        end else if (en) begin
            pos <= pos + 1'b1;
        end
    end

endmodule

// File: rtl/tape_symbol_packer.sv
// rtl/tape_symbol_packer.sv - splits rx bytes into symbols and pads frames to whole video lines
`timescale 1ns/1ps

module tape_symbol_packer
    import tape_pkg::*;
#(
    parameter int SYMBOL_W     = 4,
    parameter int FIFO_AW      = 9,
    parameter int HIGH_WATER   = 480,
    parameter int MSB_FIRST    = 1,
    parameter int LINE_SYMBOLS = 320,
    parameter int IDLE_SYMBOL  = 0,
    parameter int CNT_W        = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          rx_data,
    input  logic                rx_valid,
    output logic                rx_ready,
    input  logic                rx_last,
    input  logic                rx_user,
    output logic [SYMBOL_W-1:0] wr_data,
    output logic                wr_req,
    input  logic [FIFO_AW-1:0]  wr_used_words,
    output logic [CNT_W-1:0]    frame_count,
    output logic [CNT_W-1:0]    error_count,
    output logic                busy
);

    localparam int                  N         = symbols_per_byte(SYMBOL_W);
    localparam logic [2:0]          LAST_IDX  = 3'(N - 1);
    localparam int                  LINE_PW   = (LINE_SYMBOLS > 1) ? $clog2(LINE_SYMBOLS) : 1;
    localparam logic [LINE_PW-1:0]  LINE_LAST = LINE_PW'(LINE_SYMBOLS - 1);
    localparam logic [FIFO_AW:0]    HW_EXT    = (FIFO_AW + 1)'(HIGH_WATER);
    localparam logic [SYMBOL_W-1:0] IDLE_S    = SYMBOL_W'(IDLE_SYMBOL);

    if (!(SYMBOL_W == 1 || SYMBOL_W == 2 || SYMBOL_W == 4 || SYMBOL_W == 8)) begin : g_bad_symbol_w
        $error("tape_symbol_packer: SYMBOL_W must be 1, 2, 4 or 8");
    end
    if (LINE_SYMBOLS < 1) begin : g_bad_line_symbols
        $error("tape_symbol_packer: LINE_SYMBOLS must be >= 1");
    end

    tape_state_t         state_q, state_d;
    logic [7:0]          shift_reg;
    logic [2:0]          idx;
    logic                last_q;
    logic                user_q;
    logic                out_of_reset;
    logic                space;
    logic                emit;
    logic                load;
    logic                count_frame;
    logic                line_en;
    logic                line_wrap;
    logic [LINE_PW-1:0]  line_pos;
    logic [SYMBOL_W-1:0] cur_sym;
    logic [SYMBOL_W-1:0] emit_data;

    assign space   = ({1'b0, wr_used_words} < HW_EXT);
    assign cur_sym = SYMBOL_W'(sym_select(shift_reg, idx, SYMBOL_W, MSB_FIRST));
    assign busy    = (state_q != ST_IDLE);

    tape_line_counter #(
        .LINE_SYMBOLS (LINE_SYMBOLS),
        .POS_W        (LINE_PW)
    ) u_line (
        .clk  (clk),
        .rst  (rst),
        .en   (line_en),
        .pos  (line_pos),
        .wrap (line_wrap)
    );

    always_comb begin
        state_d     = state_q;
        rx_ready    = 1'b0;
        emit        = 1'b0;
        emit_data   = '0;
        line_en     = 1'b0;
        load        = 1'b0;
        count_frame = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Held low for the first cycle after reset so every output reads 0 in reset.
                rx_ready = out_of_reset;
                if (rx_valid && out_of_reset) begin
                    load    = 1'b1;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (space) begin
                    emit      = 1'b1;
                    emit_data = cur_sym;
                    line_en   = 1'b1;
                    if (idx == LAST_IDX) begin
                        if (last_q) begin
                            state_d = (line_pos != LINE_LAST) ? ST_PAD : ST_DONE;
                        end else begin
                            rx_ready = 1'b1;
                            if (rx_valid) load = 1'b1;
                            else          state_d = ST_IDLE;
                        end
                    end
                end
            end
            ST_PAD: begin
                if (space) begin
                    emit      = 1'b1;
                    emit_data = IDLE_S;
                    line_en   = 1'b1;
                    if (line_wrap) state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                count_frame = 1'b1;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            shift_reg    <= '0;
            idx          <= '0;
            last_q       <= 1'b0;
            user_q       <= 1'b0;
            out_of_reset <= 1'b0;
            wr_req       <= 1'b0;
            wr_data      <= '0;
        end else begin
            state_q      <= state_d;
            out_of_reset <= 1'b1;
            wr_req       <= emit;
            wr_data      <= emit_data;
            if (load) begin
                shift_reg <= rx_data;
                last_q    <= rx_last;
                user_q    <= rx_user;
                idx       <= '0;
            end else if (emit && state_q == ST_SHIFT) begin
                idx <= (idx == LAST_IDX) ? 3'd0 : idx + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_count <= '0;
            error_count <= '0;
        end else if (count_frame) begin
            if (frame_count != '1)            frame_count <= frame_count + 1'b1;
            if (user_q && error_count != '1)  error_count <= error_count + 1'b1;
        end
    end

endmodule
